// File: rtl/feedback_nand_sequencer.sv
`timescale 1ns/1ps
// Burst sequencer for the feedback-NAND toggle cell: drives the cell input per command,
// checks its output against a shadow copy of the cell and reports final state, toggles and errors.
module feedback_nand_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_len,
    output logic       cell_in,
    input  logic       cell_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_state,
    output logic [4:0] rsp_toggles,
    output logic       rsp_err,
    output logic       err_sticky
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_FORCE    = 2'b00;
    localparam logic [1:0] OP_FLIP     = 2'b01;
    localparam logic [1:0] OP_PULSE    = 2'b10;
    localparam logic [1:0] OP_RESERVED = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cell_in_q, cell_in_d;
    logic       shadow_q, shadow_d;
    logic       prev_q;
    logic [4:0] toggles_q, toggles_d;
    logic       err_q, err_d;
    logic       rsp_state_q, rsp_state_d;
    logic       sticky_q, sticky_d;
    logic       accept;
    logic       drive;
    logic       expected;

    assign accept   = cmd_valid & cmd_ready;
    // The cell sees zero while reset is held, even if the drive register still holds a RUN value.
    assign drive    = cell_in_q & ~rst;
    assign expected = ~(drive & shadow_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (cmd_op == OP_RESERVED) ? DONE : RUN;
            RUN:  if (cnt_q == 4'd0) state_d = DONE;
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The drive register is loaded one edge ahead so cell_in is already valid in each RUN cycle.
    always_comb begin
        cmd_ready = (state_q == IDLE) & ~rst;
        rsp_valid = (state_q == DONE) & ~rst;
        cell_in_d = 1'b0;
        if (state_q == IDLE && accept) begin
            cell_in_d = (cmd_op == OP_FLIP) || (cmd_op == OP_PULSE);
        end else if (state_q == RUN && cnt_q != 4'd0) begin
            case (op_q)
                OP_FORCE: cell_in_d = 1'b0;
                OP_FLIP:  cell_in_d = 1'b1;
                OP_PULSE: cell_in_d = ~cell_in_q;
                default:  cell_in_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        op_d        = op_q;
        cnt_d       = cnt_q;
        toggles_d   = toggles_q;
        err_d       = err_q;
        rsp_state_d = rsp_state_q;
        shadow_d    = expected;
        if (accept) begin
            op_d        = cmd_op;
            cnt_d       = cmd_len;
            toggles_d   = 5'd0;
            err_d       = (cmd_op == OP_RESERVED);
            rsp_state_d = cell_out;
        end else if (state_q == RUN) begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            if (cell_out != expected) err_d = 1'b1;
            if (cell_out != prev_q && toggles_q != 5'd16) toggles_d = toggles_q + 5'd1;
            if (cnt_q == 4'd0) rsp_state_d = cell_out;
        end
        sticky_d = sticky_q | ((state_d == DONE) && (state_q != DONE) && err_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_FORCE;
            cnt_q       <= 4'd0;
            cell_in_q   <= 1'b0;
            shadow_q    <= 1'b0;
            prev_q      <= 1'b1;
            toggles_q   <= 5'd0;
            err_q       <= 1'b0;
            rsp_state_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            cell_in_q   <= cell_in_d;
            shadow_q    <= shadow_d;
            prev_q      <= cell_out;
            toggles_q   <= toggles_d;
            err_q       <= err_d;
            rsp_state_q <= rsp_state_d;
            sticky_q    <= sticky_d;
        end
    end

    assign cell_in     = drive;
    assign rsp_state   = rsp_state_q & ~rst;
    assign rsp_toggles = toggles_q & {5{~rst}};
    assign rsp_err     = err_q & ~rst;
    assign err_sticky  = sticky_q;

endmodule

// File: doc/feedback_nand_sequencer.md
# feedback_nand_sequencer

Command-driven controller for the feedback-NAND toggle cell (`out = NAND(in, reg)`, `reg <= out`, reg resets to 0). It accepts burst commands over a valid/ready handshake and drives the cell input for a programmed number of cycles. It checks every cell output against an internal shadow model of the cell. When a burst finishes, it returns a response with the final cell state, a toggle count and an error flag. The block sits between the register/command front-end and one external cell instance; both share `clk` and `rst`.

## Interface
- No parameters. Widths are fixed: burst length 4 bits, toggle count 5 bits.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset (also resets the cell).
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE with `rst` low.
- `cmd_op`  in  2  00 FORCE, 01 FLIP, 10 PULSE, 11 reserved.
- `cmd_len`  in  4  burst length minus one; N = `cmd_len` + 1 (1..16).
- `cell_in`  out  1  registered drive to the cell's `input1`.
- `cell_out`  in  1  cell's `output1` (combinational NAND output).
- `rsp_valid`  out  1  response available; held until accepted.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_state`  out  1  `cell_out` sampled in the last RUN cycle.
- `rsp_toggles`  out  5  number of RUN cycles in which `cell_out` differed from its previous-cycle value (0..16).
- `rsp_err`  out  1  a mismatch occurred in this burst, or the op was reserved.
- `err_sticky`  out  1  OR of all `rsp_err` since reset.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `cell_in` = 0, which forces the cell state to 1 and parks it there.
  - Accept on `cmd_valid & cmd_ready`; latch op and N.
  - A valid op goes to RUN. Reserved op 11 goes directly to DONE with `rsp_err` = 1, `rsp_toggles` = 0, `rsp_state` = current `cell_out`.
- **RUN:** drives `cell_in` for exactly N cycles.
  - FORCE: constant 0.
  - FLIP: constant 1.
  - PULSE: 1, 0, 1, 0, ..., starting with 1.
  - A 4-bit down-counter tracks remaining cycles. RUN goes to DONE after cycle N.
- **DONE:** `rsp_valid` = 1 and `cell_in` = 0. On `rsp_ready`, go to IDLE. All `rsp_*` fields stay stable while `rsp_valid` is high.
- **Shadow model**
  - `shadow` register resets to 0.
  - Every cycle: `shadow <= ~(cell_in & shadow)`; `expected = ~(cell_in & shadow)`.
  - In each RUN cycle, `cell_out != expected` sets the burst error bit.
  - On a mismatch the shadow keeps tracking its model; it does not resync to `cell_out`.
- **Toggle tracking**
  - `prev_out` register samples `cell_out` every cycle; it resets to 1.
  - The toggle counter clears on accept and increments in each RUN cycle where `cell_out != prev_out`.
  - It saturates at 16 (no wrap possible, since N ≤ 16).
- **Error flags:** the burst error bit clears on accept. `err_sticky` sets when DONE is entered with `rsp_err` = 1 and clears only on reset.
- **Reset:** takes effect in any state, including mid-RUN or in DONE.
  - Next state is IDLE; any pending response is dropped.
  - Registers: `shadow` = 0, `prev_out` = 1, `err_sticky` = 0.
  - Outputs while `rst` is high: `cmd_ready` = 0, `cell_in` = 0, all `rsp_*` = 0.

## Timing
- Accept at edge E0 → RUN cycles are cycles 1..N after E0, with `cell_in` valid in each.
- `rsp_valid` first asserts in cycle N+1.
- Reserved op: `rsp_valid` asserts in cycle 1.
- `cmd_ready` is low from cycle 1 until the cycle after the response handshake.
- Minimum accept-to-accept spacing is N+2 cycles.
- `cell_out` is sampled before the edge that ends each RUN cycle, i.e. in the same cycle as its `cell_in`.
- The response handshake completes at the edge where `rsp_valid & rsp_ready`; IDLE (`cmd_ready` = 1) follows in the next cycle.
- There is no command/response overlap.

## Test plan
- **Reset, then FLIP, `cmd_len` = 3** (cell state 1 after idle): `cell_in` = 1,1,1,1; `cell_out` = 0,1,0,1 → `rsp_state` = 1, `rsp_toggles` = 4, `rsp_err` = 0, `rsp_valid` in cycle 5 after accept.
- **FLIP, `cmd_len` = 2, then FORCE, `cmd_len` = 5**
  - FLIP → `rsp_state` = 0, `rsp_toggles` = 3.
  - FORCE → `rsp_state` = 1, `rsp_toggles` = 0 (the first toggle back to 1 happens in DONE/IDLE, outside RUN).
- **PULSE, `cmd_len` = 3:** `cell_in` = 1,0,1,0; `cell_out` = 0,1,0,1 → `rsp_state` = 1, `rsp_toggles` = 4, no error.
- **Reserved op 11:** no RUN cycles and `cell_in` stays 0; response in cycle 1 with `rsp_err` = 1, `rsp_toggles` = 0, `rsp_state` = 1; `err_sticky` = 1 afterwards.
- **Fault and backpressure**
  - Bench forces `cell_out` = 1 in RUN cycle 1 of a FLIP → `rsp_err` = 1, `err_sticky` = 1.
  - Hold `rsp_ready` low 3 cycles → `rsp_valid` and fields stable, `cmd_ready` = 0, `cell_in` = 0.
- **Reset mid-RUN** (FLIP, `cmd_len` = 15, `rst` in cycle 5): next cycle IDLE, no `rsp_valid`, `err_sticky` = 0, `cmd_ready` = 1 one cycle after `rst` falls; a following FLIP, `cmd_len` = 0 gives `rsp_state` = 0.
